// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: cache-side and memory-side bus signals around the memory bus arbiter
// Ports (signals): ic_/dc_ command+addr, dc_data, mem2proc_response/data/tag in;
//   proc2mem_command/addr/data, ic_/dc_ response/rdata/tag, tag_error out (slave = arbiter view).
interface mem_bus_arbiter_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
);
    logic [1:0]       ic_command;
    logic [XLEN-1:0]  ic_addr;
    logic [1:0]       dc_command;
    logic [XLEN-1:0]  dc_addr;
    logic [63:0]      dc_data;
    logic [TAG_W-1:0] mem2proc_response;
    logic [63:0]      mem2proc_data;
    logic [TAG_W-1:0] mem2proc_tag;
    logic [1:0]       proc2mem_command;
    logic [XLEN-1:0]  proc2mem_addr;
    logic [63:0]      proc2mem_data;
    logic [TAG_W-1:0] ic_response;
    logic [TAG_W-1:0] dc_response;
    logic [63:0]      ic_rdata;
    logic [63:0]      dc_rdata;
    logic [TAG_W-1:0] ic_tag;
    logic [TAG_W-1:0] dc_tag;
    logic             tag_error;
    modport slave (
        input  ic_command, ic_addr, dc_command, dc_addr, dc_data,
               mem2proc_response, mem2proc_data, mem2proc_tag,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
               ic_response, dc_response, ic_rdata, dc_rdata, ic_tag, dc_tag, tag_error
    );
    modport master (
        output ic_command, ic_addr, dc_command, dc_addr, dc_data,
               mem2proc_response, mem2proc_data, mem2proc_tag,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
               ic_response, dc_response, ic_rdata, dc_rdata, ic_tag, dc_tag, tag_error
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the processor-memory bus between I-cache (0) and D-cache (1), routing load returns by tag
// Ports: clock; reset (synchronous, active-high); bus (mem_bus_arbiter_if.slave):
//   ic_/dc_ command/addr and dc_data in, proc2mem_* out to memory, mem2proc_* in from memory,
//   ic_/dc_ response/rdata/tag out to the caches, tag_error one-cycle registered pulse.
// Build option: MEM_ARB_ROUND_ROBIN_EN replaces fixed D-cache priority with round-robin.
module mem_bus_arbiter #(
    parameter int TAG_W    = 4,
    parameter int NUM_TAGS = 2**TAG_W - 1
) (
    input logic              clock,
    input logic              reset,
    mem_bus_arbiter_if.slave bus
);
    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;
    logic ic_req, dc_req, any_req, base_grant, grant, lock_q, lock_id, err_q;
    logic ret_hit, ret_miss, accept, load_acc, dup;
    logic [1:0] cmd;
    logic [TAG_W-1:0] resp, rtag;
    logic [NUM_TAGS:0] valid, owner;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_q;
`endif
    always_comb begin
        ic_req = bus.ic_command != BUS_NONE;
        dc_req = bus.dc_command != BUS_NONE;
        any_req = !reset && (ic_req || dc_req);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        base_grant = (ic_req && dc_req) ? !last_q : dc_req;
`else
        base_grant = dc_req;
`endif
        // a requester whose last attempt was rejected keeps the bus while it keeps asking
        grant = (lock_q && (lock_id ? dc_req : ic_req)) ? lock_id : base_grant;
        cmd = any_req ? (grant ? bus.dc_command : bus.ic_command) : BUS_NONE;
        resp = any_req ? bus.mem2proc_response : '0;
        rtag = reset ? '0 : bus.mem2proc_tag;
        ret_hit = rtag != '0 && valid[rtag];
        ret_miss = rtag != '0 && !valid[rtag];
        accept = resp != '0;
        load_acc = accept && cmd == BUS_LOAD;
        // a tag retiring in the same cycle it is reissued is not a collision
        dup = load_acc && valid[resp] && !(ret_hit && rtag == resp);
    end
    assign bus.proc2mem_command = cmd;
    assign bus.proc2mem_addr = any_req ? (grant ? bus.dc_addr : bus.ic_addr) : '0;
    assign bus.proc2mem_data = (any_req && grant) ? bus.dc_data : '0;
    assign bus.ic_response = grant ? '0 : resp;
    assign bus.dc_response = grant ? resp : '0;
    assign bus.ic_rdata = bus.mem2proc_data;
    assign bus.dc_rdata = bus.mem2proc_data;
    assign bus.ic_tag = (ret_hit && !owner[rtag]) ? rtag : '0;
    assign bus.dc_tag = (ret_hit && owner[rtag]) ? rtag : '0;
    assign bus.tag_error = err_q;
    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= '0;
            owner <= '0;
            lock_q <= 1'b0;
            lock_id <= 1'b0;
            err_q <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q <= 1'b0;
`endif
        end else begin
            lock_q <= any_req && !accept;
            lock_id <= grant;
            err_q <= ret_miss || dup;
            // later assignment wins, so a same-cycle reissue leaves the entry valid
            if (ret_hit) valid[rtag] <= 1'b0;
            if (load_acc) begin
                valid[resp] <= 1'b1;
                owner[resp] <= grant;
            end
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (accept) last_q <= grant;
`endif
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed table, corner sequences and random traffic against a tag-ownership model
module tb_mem_bus_arbiter;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam logic [1:0]  N  = 2'd0;
    localparam logic [1:0]  L  = 2'd1;
    localparam logic [1:0]  S  = 2'd2;
    localparam logic [31:0] IA = 32'h1000;
    localparam logic [31:0] DA = 32'h2000;

    typedef struct packed {
        logic        rst;
        logic [1:0]  ic_cmd;
        logic [1:0]  dc_cmd;
        logic [31:0] ic_addr;
        logic [31:0] dc_addr;
        logic [63:0] dc_data;
        logic [3:0]  resp;
        logic [3:0]  mtag;
        logic [63:0] mdata;
        logic [1:0]  e_cmd;
        logic [31:0] e_addr;
        logic [63:0] e_pdata;
        logic [3:0]  e_ic_resp;
        logic [3:0]  e_dc_resp;
        logic [3:0]  e_ic_tag;
        logic [3:0]  e_dc_tag;
        logic        e_terr;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    int vectors = 0;
    int miscompares = 0;
    int owners[int];
    int retry = -1;
    int last = 0;
    bit err_pend = 1'b0;
    vec_t tbl[$];

    always #5 clock = ~clock;

    mem_bus_arbiter_if #(.XLEN(32), .TAG_W(4)) bus ();
    mem_bus_arbiter #(.TAG_W(4)) dut (.clock(clock), .reset(reset), .bus(bus));

    function automatic vec_t mk(input logic r, input logic [1:0] ic, input logic [1:0] dc,
                                input logic [63:0] dd, input logic [3:0] rs, input logic [3:0] tg,
                                input logic [63:0] md, input logic [1:0] ec, input logic [31:0] ea,
                                input logic [63:0] ep, input logic [3:0] eir, input logic [3:0] edr,
                                input logic [3:0] eit, input logic [3:0] edt, input logic et);
        vec_t v;
        v = '{rst: r, ic_cmd: ic, dc_cmd: dc, ic_addr: IA, dc_addr: DA, dc_data: dd, resp: rs,
              mtag: tg, mdata: md, e_cmd: ec, e_addr: ea, e_pdata: ep, e_ic_resp: eir,
              e_dc_resp: edr, e_ic_tag: eit, e_dc_tag: edt, e_terr: et};
        return v;
    endfunction

    function automatic void chk(input string n, input logic [63:0] act, input logic [63:0] exp_v);
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s at vector %0d: got %0h, expected %0h", n, vectors, act, exp_v);
        end
    endfunction

    // drive one cycle, compare against the table (use_tbl) or the model, then advance the model
    task automatic step(input vec_t v, input bit use_tbl);
        vec_t e;
        int g;
        bit ir, dr, any, hit, acc_load, nerr;
        reset = v.rst;
        bus.ic_command = v.ic_cmd;
        bus.ic_addr = v.ic_addr;
        bus.dc_command = v.dc_cmd;
        bus.dc_addr = v.dc_addr;
        bus.dc_data = v.dc_data;
        bus.mem2proc_response = v.resp;
        bus.mem2proc_tag = v.mtag;
        bus.mem2proc_data = v.mdata;
        #2;
        e = v;
        ir = v.ic_cmd != N;
        dr = v.dc_cmd != N;
        any = !v.rst && (ir || dr);
        if (retry >= 0 && (retry == 1 ? dr : ir)) g = retry;
        else if (ir && dr) g = RR ? 1 - last : 1;
        else g = dr ? 1 : 0;
        hit = !v.rst && v.mtag != 4'd0 && owners.exists(int'(v.mtag));
        if (!use_tbl) begin
            e.e_cmd = any ? (g == 1 ? v.dc_cmd : v.ic_cmd) : N;
            e.e_addr = any ? (g == 1 ? v.dc_addr : v.ic_addr) : 32'd0;
            e.e_pdata = (any && g == 1) ? v.dc_data : 64'd0;
            e.e_ic_resp = (any && g == 0) ? v.resp : 4'd0;
            e.e_dc_resp = (any && g == 1) ? v.resp : 4'd0;
            e.e_ic_tag = (hit && owners[int'(v.mtag)] == 0) ? v.mtag : 4'd0;
            e.e_dc_tag = (hit && owners[int'(v.mtag)] == 1) ? v.mtag : 4'd0;
            e.e_terr = err_pend;
        end
        vectors++;
        chk("proc2mem_command", 64'(bus.proc2mem_command), 64'(e.e_cmd));
        chk("proc2mem_addr", 64'(bus.proc2mem_addr), 64'(e.e_addr));
        chk("proc2mem_data", bus.proc2mem_data, e.e_pdata);
        chk("ic_response", 64'(bus.ic_response), 64'(e.e_ic_resp));
        chk("dc_response", 64'(bus.dc_response), 64'(e.e_dc_resp));
        chk("ic_tag", 64'(bus.ic_tag), 64'(e.e_ic_tag));
        chk("dc_tag", 64'(bus.dc_tag), 64'(e.e_dc_tag));
        chk("tag_error", 64'(bus.tag_error), 64'(e.e_terr));
        if (e.e_ic_tag != 4'd0) chk("ic_rdata", bus.ic_rdata, v.mdata);
        if (e.e_dc_tag != 4'd0) chk("dc_rdata", bus.dc_rdata, v.mdata);
        if (v.rst) begin
            owners.delete();
            retry = -1;
            last = 0;
            err_pend = 1'b0;
        end else begin
            acc_load = any && v.resp != 4'd0 && (g == 1 ? v.dc_cmd : v.ic_cmd) == L;
            nerr = (v.mtag != 4'd0 && !hit) ||
                   (acc_load && owners.exists(int'(v.resp)) && !(hit && v.mtag == v.resp));
            if (hit) owners.delete(int'(v.mtag));
            if (acc_load) owners[int'(v.resp)] = g;
            retry = (any && v.resp == 4'd0) ? g : -1;
            if (any && v.resp != 4'd0) last = g;
            err_pend = nerr;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        vec_t v;
        bit d;
        logic [3:0] r;
        reset = 1'b1;
        bus.ic_command = N;
        bus.ic_addr = '0;
        bus.dc_command = N;
        bus.dc_addr = '0;
        bus.dc_data = '0;
        bus.mem2proc_response = '0;
        bus.mem2proc_tag = '0;
        bus.mem2proc_data = '0;
        @(posedge clock);
        @(negedge clock);
        // reset held with both requesting
        repeat (3) tbl.push_back(mk(1, L, L, 0, 3, 7, 0, N, 0, 0, 0, 0, 0, 0, 0));
        // both load: D wins, tag 3 returns to D
        tbl.push_back(mk(0, L, L, 0, 3, 0, 0, L, DA, 0, 0, 3, 0, 0, 0));
        tbl.push_back(mk(0, N, N, 0, 0, 3, 64'hDEAD, N, 0, 0, 0, 0, 0, 3, 0));
        // I rejected, keeps grant against D next cycle
        tbl.push_back(mk(0, L, N, 0, 0, 0, 0, L, IA, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, L, L, 0, 5, 0, 0, L, IA, 0, 5, 0, 0, 0, 0));
        // untracked tag 7: one-cycle error pulse
        tbl.push_back(mk(0, N, N, 0, 0, 7, 64'h11, N, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, N, N, 0, 0, 0, 0, N, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, N, N, 0, 0, 0, 0, N, 0, 0, 0, 0, 0, 0, 0));
        // tag 2 returns to I while D reclaims it
        tbl.push_back(mk(0, L, N, 0, 2, 0, 0, L, IA, 0, 2, 0, 0, 0, 0));
        tbl.push_back(mk(0, N, L, 0, 2, 2, 64'hBEEF, L, DA, 0, 0, 2, 2, 0, 0));
        tbl.push_back(mk(0, N, N, 0, 0, 2, 64'hCAFE, N, 0, 0, 0, 0, 0, 2, 0));
        tbl.push_back(mk(0, N, N, 0, 0, 0, 0, N, 0, 0, 0, 0, 0, 0, 0));
        // D accepted onto live tag 5 (owned by I): error, ownership moves to D
        tbl.push_back(mk(0, N, L, 0, 5, 0, 0, L, DA, 0, 0, 5, 0, 0, 0));
        tbl.push_back(mk(0, N, N, 0, 0, 5, 64'h5555, N, 0, 0, 0, 0, 0, 5, 1));
        tbl.push_back(mk(0, N, N, 0, 0, 0, 0, N, 0, 0, 0, 0, 0, 0, 0));
        // store is forwarded but not tracked
        tbl.push_back(mk(0, N, S, 64'h1234, 4, 0, 0, S, DA, 64'h1234, 0, 4, 0, 0, 0));
        tbl.push_back(mk(0, N, N, 0, 0, 4, 64'h77, N, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, N, N, 0, 0, 0, 0, N, 0, 0, 0, 0, 0, 0, 1));
        // reset drops outstanding tag 9
        tbl.push_back(mk(0, L, N, 0, 9, 0, 0, L, IA, 0, 9, 0, 0, 0, 0));
        tbl.push_back(mk(1, N, N, 0, 0, 0, 0, N, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, N, N, 0, 0, 9, 64'h99, N, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, N, N, 0, 0, 0, 0, N, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, N, N, 0, 0, 0, 0, N, 0, 0, 0, 0, 0, 0, 0));
        foreach (tbl[i]) step(tbl[i], 1'b1);
        // continuous dual loads, all accepted: alternate with round-robin, else always D
        step(mk(1, N, N, 0, 0, 0, 0, N, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        for (int i = 0; i < 4; i++) begin
            d = RR ? (i % 2 == 0) : 1'b1;
            r = 4'(i + 1);
            step(mk(0, L, L, 64'h77, r, 0, 0, L, d ? DA : IA, d ? 64'h77 : 64'h0,
                    d ? 4'd0 : r, d ? r : 4'd0, 0, 0, 0), 1'b1);
        end
        // random traffic against the model
        v = '0;
        v.rst = 1'b1;
        step(v, 1'b0);
        for (int i = 0; i < 500; i++) begin
            v = '0;
            v.rst = $urandom_range(0, 49) == 0;
            v.ic_cmd = 2'($urandom_range(0, 2));
            v.dc_cmd = 2'($urandom_range(0, 2));
            v.ic_addr = $urandom;
            v.dc_addr = $urandom;
            v.dc_data = {$urandom, $urandom};
            v.resp = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            v.mtag = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            v.mdata = {$urandom, $urandom};
            step(v, 1'b0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
